// File: rtl/display_fb_arbiter.sv
// display_fb_arbiter
// Shares the single-port display frame buffer between raster-order scan-out
// prefetch and host pixel writes. Prefetched pixels are buffered in a small
// FIFO and handed to the display one per pixel_req. Host writes get every
// RAM cycle the prefetch does not urgently need.
//
// Ports:
//   clk, reset_n      system clock, synchronous active-low reset
//   frame_start       one-cycle pulse: restart fetch at address 0, flush FIFO
//   pixel_req         display consumes one pixel this cycle
//   pixel_data/valid  registered pixel, valid one cycle after pixel_req
//   underflow         sticky: pixel_req found the FIFO empty
//   wr_valid/ready    host write handshake (wr_ready is combinational)
//   wr_addr/wr_data   host write address / data
//   mem_en/we/addr/wdata  RAM command (combinational, issued this cycle)
//   mem_rdata         RAM read data, valid one cycle after a read issue
module display_fb_arbiter #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 400,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WATER  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              pixel_req,
  output logic [DATA_W-1:0] pixel_data,
  output logic              pixel_valid,
  output logic              underflow,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]     LW_C      = CW'(LOW_WATER);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_addr;
  logic              rd_inflight;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, occ;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  logic fetching, urgent, rd_issue, wr_fire, push, pop;

  // occupancy counts the read still in flight so the FIFO never overfills
  assign occ = count + CW'(rd_inflight);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    if (frame_start)
      state_nxt = FETCH;
    else if (state == FETCH && rd_issue && fetch_addr == LAST_ADDR)
      state_nxt = DONE;
  end

  // ---------------- FSM: outputs / arbitration ----------------
  // wr_ready only drops for an urgent read. A non-urgent read only takes the
  // slot when no write is offered, so wr_ready never has to look at wr_valid.
  always_comb begin
    fetching  = 1'b0;
    urgent    = 1'b0;
    rd_issue  = 1'b0;
    wr_ready  = 1'b0;
    wr_fire   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n) begin
      fetching = (state == FETCH) && !frame_start;
      urgent   = fetching && (occ < LW_C);
      rd_issue = urgent || (fetching && !wr_valid && (occ < DEPTH_C));
      wr_ready = !urgent;
      wr_fire  = wr_valid && wr_ready;
      if (rd_issue) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end else if (wr_fire) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
      end
    end
  end

  // ---------------- fetch address / in-flight tracking ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_addr  <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (frame_start)   fetch_addr <= '0;
      else if (rd_issue) fetch_addr <= fetch_addr + ADDR_W'(1);
      rd_inflight <= rd_issue;
    end
  end

  // read data returning during a frame_start cycle belongs to the old frame
  assign push = rd_inflight && !frame_start;
  assign pop  = pixel_req && (count != '0) && !frame_start;

  // ---------------- prefetch FIFO ----------------
  always_ff @(posedge clk) begin
    if (!reset_n || frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // ---------------- pixel output ----------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      underflow   <= 1'b0;
    end else if (frame_start) begin
      pixel_valid <= 1'b0;
    end else if (pixel_req) begin
      if (count != '0) begin
        pixel_data  <= fifo_mem[rd_ptr];
        pixel_valid <= 1'b1;
      end else begin
        pixel_data  <= '0;
        pixel_valid <= 1'b0;
        underflow   <= 1'b1;
      end
    end else begin
      pixel_valid <= 1'b0;
    end
  end

endmodule
